// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_controller
//  Purpose  : Two-road intersection sequencer (NS main road, EW side road)
//             with a pedestrian walk phase. NS green is the resting phase.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_controller #(
    parameter int CNT_W     = 5,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int PED_T     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] state
);

    // State encoding is visible on the debug port, so codes are fixed.
    localparam logic [2:0] S_NS_GREEN  = 3'd0;
    localparam logic [2:0] S_NS_YELLOW = 3'd1;
    localparam logic [2:0] S_ALL_RED_A = 3'd2;
    localparam logic [2:0] S_PED_WALK  = 3'd3;
    localparam logic [2:0] S_EW_GREEN  = 3'd4;
    localparam logic [2:0] S_EW_YELLOW = 3'd5;
    localparam logic [2:0] S_ALL_RED_B = 3'd6;

    // Lamp patterns {red,yellow,green}.
    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_YELLOW = 3'b010;
    localparam logic [2:0] c_GREEN  = 3'b001;

    // Terminal timer values: a phase held T cycles exits when timer == T-1.
    localparam logic [CNT_W-1:0] c_GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_PED_LAST    = CNT_W'(PED_T - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_timer;
    logic             r_car_pending;
    logic             r_ped_pending;
    logic             w_change;
    logic             w_enter_ew;
    logic             w_enter_ped;

    assign w_change    = (w_next != r_state);
    assign w_enter_ew  = (w_next == S_EW_GREEN) && (r_state != S_EW_GREEN);
    assign w_enter_ped = (w_next == S_PED_WALK) && (r_state != S_PED_WALK);
    assign state       = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_NS_GREEN;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase timer: restarts on every state change; parks at the minimum
    // green value while NS green is resting so a request is served at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_change) begin
            r_timer <= '0;
        end else if ((r_state == S_NS_GREEN) && (r_timer == c_GMIN_LAST)) begin
            r_timer <= r_timer;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Request latches; entering the served phase clears, and clear beats set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_car_pending <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            if (w_enter_ew) begin
                r_car_pending <= 1'b0;
            end else if (ew_car) begin
                r_car_pending <= 1'b1;
            end

            if (w_enter_ped) begin
                r_ped_pending <= 1'b0;
            end else if (ped_req && (r_state != S_PED_WALK)) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_NS_GREEN: begin
                if ((r_timer == c_GMIN_LAST) &&
                    (r_car_pending || r_ped_pending || ew_car || ped_req)) begin
                    w_next = S_NS_YELLOW;
                end
            end
            S_NS_YELLOW: begin
                if (r_timer == c_YELLOW_LAST) begin
                    w_next = S_ALL_RED_A;
                end
            end
            S_ALL_RED_A: begin
                if (r_timer == c_ALLRED_LAST) begin
                    if (r_ped_pending) begin
                        w_next = S_PED_WALK;
                    end else if (r_car_pending) begin
                        w_next = S_EW_GREEN;
                    end else begin
                        w_next = S_NS_GREEN;
                    end
                end
            end
            S_PED_WALK: begin
                if (r_timer == c_PED_LAST) begin
                    if (r_car_pending || ew_car) begin
                        w_next = S_EW_GREEN;
                    end else begin
                        w_next = S_NS_GREEN;
                    end
                end
            end
            S_EW_GREEN: begin
                if ((r_timer == c_GMAX_LAST) ||
                    ((r_timer >= c_GMIN_LAST) && !ew_car)) begin
                    w_next = S_EW_YELLOW;
                end
            end
            S_EW_YELLOW: begin
                if (r_timer == c_YELLOW_LAST) begin
                    w_next = S_ALL_RED_B;
                end
            end
            S_ALL_RED_B: begin
                if (r_timer == c_ALLRED_LAST) begin
                    w_next = S_NS_GREEN;
                end
            end
            default: begin
                w_next = S_NS_GREEN;
            end
        endcase
    end

    // Lamp decode: each road is red unless in its own green/yellow phase.
    always_comb begin
        ns_light = c_RED;
        ew_light = c_RED;
        ped_walk = 1'b0;
        case (r_state)
            S_NS_GREEN:  ns_light = c_GREEN;
            S_NS_YELLOW: ns_light = c_YELLOW;
            S_EW_GREEN:  ew_light = c_GREEN;
            S_EW_YELLOW: ew_light = c_YELLOW;
            S_PED_WALK:  ped_walk = 1'b1;
            default: begin
                ns_light = c_RED;
                ew_light = c_RED;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_controller
//  Purpose  : Directed scoreboard bench for traffic_light_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

    localparam logic [2:0] NSG = 3'd0;
    localparam logic [2:0] NSY = 3'd1;
    localparam logic [2:0] ARA = 3'd2;
    localparam logic [2:0] PW  = 3'd3;
    localparam logic [2:0] EWG = 3'd4;
    localparam logic [2:0] EWY = 3'd5;
    localparam logic [2:0] ARB = 3'd6;

    logic       clk;
    logic       reset;
    logic       ew_car;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    logic stim_done = 1'b0;

    traffic_light_controller dut (
        .clk      (clk),
        .reset    (reset),
        .ew_car   (ew_car),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ped_walk (ped_walk),
        .state    (state)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamps for a given state, straight from the lamp rules.
    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e.st   = st;
        e.ns   = 3'b100;
        e.ew   = 3'b100;
        e.walk = 1'b0;
        case (st)
            NSG: e.ns = 3'b001;
            NSY: e.ns = 3'b010;
            EWG: e.ew = 3'b001;
            EWY: e.ew = 3'b010;
            PW:  e.walk = 1'b1;
            default: e.walk = 1'b0;
        endcase
        return e;
    endfunction

    // One cycle: apply inputs for this cycle and queue the expected state
    // visible during it; then advance to just after the next rising edge.
    task automatic cyc(input logic ew, input logic ped, input logic [2:0] st);
        ew_car  = ew;
        ped_req = ped;
        exp_q.push_back(mk(st));
        n_pushed++;
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input int n, input logic ew, input logic ped, input logic [2:0] st);
        for (int i = 0; i < n; i++) cyc(ew, ped, st);
    endtask

    // Assert reset for two edges; optionally check the state shown in the
    // cycle where reset is first raised, then NS green after the first edge.
    task automatic do_reset(input logic chk_pre, input logic [2:0] pre);
        reset   = 1'b1;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        if (chk_pre) begin
            exp_q.push_back(mk(pre));
            n_pushed++;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(mk(NSG));
        n_pushed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Car pulse in cycle 2, full side-road service, back to NS green at 26.
    task automatic car_pulse_seq();
        seg(2, 1'b0, 1'b0, NSG);
        cyc(1'b1, 1'b0, NSG);
        seg(5, 1'b0, 1'b0, NSG);
        seg(3, 1'b0, 1'b0, NSY);
        seg(2, 1'b0, 1'b0, ARA);
        seg(8, 1'b0, 1'b0, EWG);
        seg(3, 1'b0, 1'b0, EWY);
        seg(2, 1'b0, 1'b0, ARB);
        seg(2, 1'b0, 1'b0, NSG);
    endtask

    // Monitor: every cycle with a queued expectation, pop and compare.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if ({state, ns_light, ew_light, ped_walk} !== e) begin
                n_errors++;
                $display("FAIL lamps t=%0t: got state=%0d ns=%b ew=%b walk=%b, want state=%0d ns=%b ew=%b walk=%b",
                         $time, state, ns_light, ew_light, ped_walk, e.st, e.ns, e.ew, e.walk);
            end
            n_checks++;
            if ((ns_light[1:0] != 2'b00 && ew_light[1:0] != 2'b00) ||
                (ped_walk && (ns_light != 3'b100 || ew_light != 3'b100))) begin
                n_errors++;
                $display("FAIL safety t=%0t: got ns=%b ew=%b walk=%b, want no conflicting go lamps",
                         $time, ns_light, ew_light, ped_walk);
            end
        end
    end

    // Stimulus.
    initial begin
        reset   = 1'b1;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        @(posedge clk);
        #1;

        // Quiet road.
        do_reset(1'b0, NSG);
        seg(50, 1'b0, 1'b0, NSG);

        // Car pulse.
        do_reset(1'b0, NSG);
        car_pulse_seq();

        // Car held high: EW green capped at 16, NS green exactly 8.
        do_reset(1'b0, NSG);
        seg(8, 1'b1, 1'b0, NSG);
        seg(3, 1'b1, 1'b0, NSY);
        seg(2, 1'b1, 1'b0, ARA);
        seg(16, 1'b1, 1'b0, EWG);
        seg(3, 1'b1, 1'b0, EWY);
        seg(2, 1'b1, 1'b0, ARB);
        seg(8, 1'b1, 1'b0, NSG);
        seg(1, 1'b1, 1'b0, NSY);

        // Pedestrian only, pulse at cycle 20; a press during walk is ignored.
        do_reset(1'b1, NSY);
        seg(20, 1'b0, 1'b0, NSG);
        cyc(1'b0, 1'b1, NSG);
        seg(3, 1'b0, 1'b0, NSY);
        seg(2, 1'b0, 1'b0, ARA);
        seg(2, 1'b0, 1'b0, PW);
        cyc(1'b0, 1'b1, PW);
        seg(3, 1'b0, 1'b0, PW);
        seg(12, 1'b0, 1'b0, NSG);

        // Car and pedestrian together at cycle 3: walk first, then EW,
        // then NS rests because both requests were consumed.
        do_reset(1'b0, NSG);
        seg(3, 1'b0, 1'b0, NSG);
        cyc(1'b1, 1'b1, NSG);
        seg(4, 1'b0, 1'b0, NSG);
        seg(3, 1'b0, 1'b0, NSY);
        seg(2, 1'b0, 1'b0, ARA);
        seg(6, 1'b0, 1'b0, PW);
        seg(8, 1'b0, 1'b0, EWG);
        seg(3, 1'b0, 1'b0, EWY);
        seg(2, 1'b0, 1'b0, ARB);
        seg(12, 1'b0, 1'b0, NSG);

        // Reset during EW green while the car flag is being re-armed.
        do_reset(1'b0, NSG);
        seg(8, 1'b1, 1'b0, NSG);
        seg(3, 1'b0, 1'b0, NSY);
        seg(2, 1'b0, 1'b0, ARA);
        seg(4, 1'b1, 1'b0, EWG);
        do_reset(1'b1, EWG);
        seg(12, 1'b0, 1'b0, NSG);
        do_reset(1'b0, NSG);
        car_pulse_seq();

        stim_done = 1'b1;
    end

    // Drain the scoreboard and report; bounded by a time limit.
    initial begin
        fork
            begin
                wait (stim_done);
                @(negedge clk);
                @(negedge clk);
            end
            begin
                #100000;
                n_errors++;
                $display("FAIL timeout: got stimulus incomplete, want completion within time limit");
            end
        join_any
        disable fork;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        n_checks++;
        if (n_checks < 2 * n_pushed + 1) begin
            n_errors++;
            $display("FAIL coverage: got %0d checks, want at least %0d", n_checks, 2 * n_pushed + 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
- Two-road intersection sequencer: main road (NS) and side road (EW), with a pedestrian walk phase.
- Holds NS green by default. Serves EW when a side-road car is detected, and a walk interval when a pedestrian requests.
- Drives one-hot lamp outputs per road plus a walk lamp. Sits above the lamp-storage latches in the traffic-light design.

Parameters:
- CNT_W, 5: phase-timer width.
- GREEN_MIN, 8: minimum green cycles, either road.
- GREEN_MAX, 16: maximum EW green cycles.
- YELLOW_T, 3: yellow cycles.
- ALLRED_T, 2: all-red clearance cycles.
- PED_T, 6: walk cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- ew_car  in  1  side-road car sensor, level.
- ped_req  in  1  pedestrian button, level or pulse.
- ns_light  out  3  one-hot {red,yellow,green}; bit0 = green.
- ew_light  out  3  one-hot {red,yellow,green}.
- ped_walk  out  1  walk lamp.
- state  out  3  current state encoding, for debug.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset); sampled on the rising edge of clk.
- Reset values: state=NS_GREEN (0); timer=0; car_pending=0; ped_pending=0; ns_light=3'b001; ew_light=3'b100; ped_walk=0. Reset mid-phase takes effect on the next edge from any state.
- Outputs are a combinational decode of the state register and change on the same edge as the state.
- Lamp decode: red is on in every state except the road's own green/yellow. ped_walk=1 only in PED_WALK.
- State encoding: NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, PED_WALK=3, EW_GREEN=4, EW_YELLOW=5, ALL_RED_B=6. Code 7 is illegal and goes to NS_GREEN.
- Timer: cleared to 0 on every state change; otherwise increments each cycle. In NS_GREEN it saturates at GREEN_MIN-1. A state held T cycles exits on the edge where timer==T-1.
- Flags:
  - car_pending sets on any cycle with ew_car=1 and clears on entry to EW_GREEN.
  - ped_pending sets on ped_req=1 and clears on entry to PED_WALK.
  - ped_req during PED_WALK is ignored.
  - Set and clear in the same cycle: clear wins.
- Transitions:
  - NS_GREEN -> NS_YELLOW when timer==GREEN_MIN-1 and (car_pending|ped_pending|ew_car|ped_req); otherwise hold.
  - NS_YELLOW -> ALL_RED_A after YELLOW_T cycles.
  - ALL_RED_A, after ALLRED_T cycles: -> PED_WALK if ped_pending; else -> EW_GREEN if car_pending; else -> NS_GREEN. The last case is unreachable in normal operation.
  - PED_WALK, after PED_T cycles: -> EW_GREEN if car_pending|ew_car; else -> NS_GREEN.
  - EW_GREEN -> EW_YELLOW when timer==GREEN_MAX-1, or when timer>=GREEN_MIN-1 and ew_car=0.
  - EW_YELLOW -> ALL_RED_B after YELLOW_T cycles.
  - ALL_RED_B -> NS_GREEN after ALLRED_T cycles.
- Safety invariant: ns_light and ew_light never show green/yellow simultaneously. ped_walk=1 implies both roads red.
- Parameter legality: all timing parameters >=1; GREEN_MAX>=GREEN_MIN; all values < 2^CNT_W. Illegal values are unsupported.

Test Plan:
- Quiet road:
  - Stimulus: reset, then 50 cycles with no inputs.
  - Required: state=0 throughout; ns_light=001, ew_light=100, ped_walk=0.
- Car pulse (cycle 0 = first edge after reset released):
  - Stimulus: ew_car high cycle 2 only.
  - Required sequence: NS_GREEN cycles 0-7; NS_YELLOW 8-10 (ns_light=010); ALL_RED_A 11-12; EW_GREEN 13-20 (ew_light=001); EW_YELLOW 21-23; ALL_RED_B 24-25; NS_GREEN at 26.
- Car held high:
  - Stimulus: ew_car=1 continuously.
  - Required: EW_GREEN exactly 16 cycles; NS_GREEN then lasts exactly 8 cycles before re-cycling.
- Pedestrian only:
  - Stimulus: ped_req pulse at cycle 20.
  - Required: NS_YELLOW 21-23; ALL_RED_A 24-25; PED_WALK 26-31 with ped_walk=1 and both roads 100; NS_GREEN at 32.
- Car and pedestrian together:
  - Stimulus: ew_car and ped_req both pulsed at cycle 3.
  - Required: PED_WALK 6 cycles, then EW_GREEN; both flags clear.
- Reset mid-phase:
  - Stimulus: reset asserted during EW_GREEN.
  - Required: next edge gives NS_GREEN, ew_light=100, flags 0. A later ew_car pulse follows the full car-pulse timing.
